// File: rtl/collatz_pkg.sv
// Shared types and helpers for the multi-lane Collatz sweeper.
// Optional max tracking is enabled with COLLATZ_SWEEP_MAXTRACK_EN.
package collatz_pkg;

    typedef enum logic [1:0] {
        L_IDLE,
        L_RUN,
        L_WAIT
    } lane_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } sweep_state_t;

    // True when 3n+1 does not fit in w bits (w <= 64).
    function automatic logic mul3_ovf(input logic [63:0] n, input int w);
        logic [65:0] t;
        t = {2'b00, n} + {1'b0, n, 1'b0} + 66'd1;
        return (t >> w) != 66'd0;
    endfunction

endpackage

// File: rtl/collatz_sweep_if.sv
// Host-side bundle of the Collatz sweeper: control, status, read port.
// COLLATZ_SWEEP_MAXTRACK_EN adds max_count/max_start.
interface collatz_sweep_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int ADDR_BITS   = 4
);
    logic                   go;
    logic [DATA_WIDTH-1:0]  start;
    logic                   busy;
    logic                   done;
    logic [ADDR_BITS-1:0]   raddr;
    logic [COUNT_WIDTH-1:0] rdata;
    logic                   rovf;
`ifdef COLLATZ_SWEEP_MAXTRACK_EN
    logic [COUNT_WIDTH-1:0] max_count;
    logic [DATA_WIDTH-1:0]  max_start;

    modport master (
        output go, start, raddr,
        input  busy, done, rdata, rovf,
        input  max_count, max_start
    );
    modport slave (
        input  go, start, raddr,
        output busy, done, rdata, rovf,
        output max_count, max_start
    );
`else
    modport master (
        output go, start, raddr,
        input  busy, done, rdata, rovf
    );
    modport slave (
        input  go, start, raddr,
        output busy, done, rdata, rovf
    );
`endif
endinterface

// File: rtl/collatz_lane.sv
// One Collatz iterator: load, step until n==1 or overflow, then hold
// the result and request the write port until granted.
module collatz_lane
    import collatz_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int ADDR_BITS   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  n_in,
    input  logic [ADDR_BITS-1:0]   tag_in,
    input  logic                   grant,
    output logic                   req,
    output logic                   idle,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   ovf,
    output logic [ADDR_BITS-1:0]   tag
);

    lane_state_t           st;
    logic [DATA_WIDTH-1:0] n;
    logic [DATA_WIDTH-1:0] nx;
    logic                  oflow;

    always_comb begin
        oflow = 1'b0;
        nx    = n >> 1;
        if (n[0]) begin
            oflow = mul3_ovf(64'(n), DATA_WIDTH);
            nx    = n + (n << 1) + DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st    <= L_IDLE;
            n     <= '0;
            count <= '0;
            ovf   <= 1'b0;
            tag   <= '0;
        end else begin
            unique case (st)
                L_IDLE: if (load) begin
                    n     <= n_in;
                    tag   <= tag_in;
                    count <= '0;
                    ovf   <= 1'b0;
                    st    <= (n_in <= DATA_WIDTH'(1)) ? L_WAIT : L_RUN;
                end
                L_RUN: if (oflow) begin
                    ovf   <= 1'b1;
                    count <= '1;
                    st    <= L_WAIT;
                end else begin
                    n <= nx;
                    if (count != '1) count <= count + COUNT_WIDTH'(1);
                    if (nx == DATA_WIDTH'(1)) st <= L_WAIT;
                end
                L_WAIT: if (grant) st <= L_IDLE;
                default: st <= L_IDLE;
            endcase
        end
    end

    assign req  = (st == L_WAIT);
    assign idle = (st == L_IDLE);

endmodule

// File: rtl/collatz_sweep.sv
// Multi-lane Collatz range sweeper with result RAM and registered read port.
// Define COLLATZ_SWEEP_MAXTRACK_EN to add max_count/max_start tracking.
module collatz_sweep
    import collatz_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int RAM_WORDS   = 16,
    parameter int ADDR_BITS   = 4,
    parameter int LANES       = 4
) (
    input logic            clk,
    input logic            reset_n,
    collatz_sweep_if.slave bus
);

    localparam int IW = ADDR_BITS + 1;

    sweep_state_t          st;
    logic [DATA_WIDTH-1:0] base;
    logic [IW-1:0]         idx;
    logic                  busy_q;
    logic                  done_q;

    logic [LANES-1:0]       idle;
    logic [LANES-1:0]       req;
    logic [LANES-1:0]       load;
    logic [LANES-1:0]       gnt;
    logic [LANES-1:0]       ovf_l;
    logic [COUNT_WIDTH-1:0] cnt [LANES];
    logic [ADDR_BITS-1:0]   tag [LANES];

    logic                   disp;
    logic                   we;
    logic [ADDR_BITS-1:0]   waddr;
    logic [COUNT_WIDTH:0]   wdata;
    logic                   all_free;
    logic [DATA_WIDTH-1:0]  nval;

    logic [COUNT_WIDTH:0]   mem [2**ADDR_BITS];
    logic [COUNT_WIDTH-1:0] rdata_q;
    logic                   rovf_q;

    // Lowest idle lane takes the next value; lowest finished lane writes.
    always_comb begin
        disp  = 1'b0;
        load  = '0;
        we    = 1'b0;
        gnt   = '0;
        waddr = '0;
        wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            if (idle[i] && !disp && st == RUN) begin
                disp    = 1'b1;
                load[i] = 1'b1;
            end
            if (req[i] && !we) begin
                we     = 1'b1;
                gnt[i] = 1'b1;
                waddr  = tag[i];
                wdata  = {ovf_l[i], cnt[i]};
            end
        end
    end

    assign nval     = base + DATA_WIDTH'(idx);
    assign all_free = &(idle | gnt);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        collatz_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .COUNT_WIDTH(COUNT_WIDTH),
            .ADDR_BITS  (ADDR_BITS)
        ) u_lane (
            .clk   (clk),
            .reset_n(reset_n),
            .load  (load[g]),
            .n_in  (nval),
            .tag_in(idx[ADDR_BITS-1:0]),
            .grant (gnt[g]),
            .req   (req[g]),
            .idle  (idle[g]),
            .count (cnt[g]),
            .ovf   (ovf_l[g]),
            .tag   (tag[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st     <= IDLE;
            base   <= '0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (st)
                IDLE: if (bus.go) begin
                    base   <= bus.start;
                    idx    <= '0;
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    st     <= RUN;
                end
                RUN: if (disp) begin
                    idx <= idx + IW'(1);
                    if (idx == IW'(RAM_WORDS - 1)) st <= FLUSH;
                end
                FLUSH: if (all_free) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    st     <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Nonblocking read gives the pre-write word on a same-address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            rovf_q  <= 1'b0;
        end else begin
            {rovf_q, rdata_q} <= mem[bus.raddr];
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.rovf  = rovf_q;

`ifdef COLLATZ_SWEEP_MAXTRACK_EN
    logic [COUNT_WIDTH-1:0] max_q;
    logic [DATA_WIDTH-1:0]  maxs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_q  <= '0;
            maxs_q <= '0;
        end else if (st == IDLE && bus.go) begin
            max_q  <= '0;
            maxs_q <= '0;
        end else if (we && wdata[COUNT_WIDTH-1:0] > max_q) begin
            max_q  <= wdata[COUNT_WIDTH-1:0];
            maxs_q <= base + DATA_WIDTH'(waddr);
        end
    end

    assign bus.max_count = max_q;
    assign bus.max_start = maxs_q;
`endif

endmodule

// File: tb/tb_collatz_sweep.sv
// Bench for collatz_sweep: three configurations driven in lockstep and
// checked against a plain-arithmetic Collatz model.
module tb_collatz_sweep;

    logic clk;
    logic reset_n;

    int n_chk  = 0;
    int n_pass = 0;

    collatz_sweep_if #(.DATA_WIDTH(32)) if0 ();
    collatz_sweep_if #(.DATA_WIDTH(32)) if1 ();
    collatz_sweep_if #(.DATA_WIDTH(8))  if2 ();

    collatz_sweep #(.DATA_WIDTH(32), .LANES(4)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(if0));
    collatz_sweep #(.DATA_WIDTH(32), .LANES(1)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(if1));
    collatz_sweep #(.DATA_WIDTH(8), .LANES(4)) u2 (
        .clk(clk), .reset_n(reset_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, count} for start value v in a w-bit datapath.
    function automatic logic [16:0] model(longint unsigned v, int w);
        longint unsigned n;
        longint unsigned lim;
        int c;
        n   = v;
        c   = 0;
        lim = 64'd1 << w;
        if (n <= 1) return 17'd0;
        while (n != 1) begin
            if (n % 2 == 1) begin
                if (3 * n + 1 >= lim) return {1'b1, 16'hFFFF};
                n = 3 * n + 1;
            end else begin
                n = n / 2;
            end
            c++;
        end
        if (c > 65535) return {1'b0, 16'hFFFF};
        return {1'b0, 16'(c)};
    endfunction

    task automatic chk(string name, longint unsigned act, longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    longint unsigned cur_start;
    logic            rd_en;
    logic            pv;
    logic [3:0]      pa;
    logic            bprev;

    always @(posedge clk) begin
        pv <= rd_en;
        pa <= if0.raddr;
    end

    // Read-port compare: every cycle a registered read is pending.
    always @(negedge clk) begin
        if (pv) begin
            chk($sformatf("l4w32_a%0d", pa), {if0.rovf, if0.rdata},
                model((cur_start + pa) & 64'hFFFF_FFFF, 32));
            chk($sformatf("l1w32_a%0d", pa), {if1.rovf, if1.rdata},
                model((cur_start + pa) & 64'hFFFF_FFFF, 32));
            chk($sformatf("l4w8_a%0d", pa), {if2.rovf, if2.rdata},
                model((cur_start + pa) & 64'hFF, 8));
        end
    end

    // busy must fall in exactly the cycle done rises.
    always @(negedge clk) begin
        if (!reset_n) begin
            bprev = 1'b0;
        end else begin
            if (bprev && !if0.busy) chk("busy_fall_done", if0.done, 1);
            bprev = if0.busy;
        end
    end

    task automatic set_go(logic g, longint unsigned s);
        if0.go = g;  if0.start = s[31:0];
        if1.go = g;  if1.start = s[31:0];
        if2.go = g;  if2.start = s[7:0];
    endtask

    task automatic set_raddr(logic [3:0] a);
        if0.raddr = a;
        if1.raddr = a;
        if2.raddr = a;
    endtask

    task automatic kick(longint unsigned s);
        cur_start = s;
        @(negedge clk);
        set_go(1'b1, s);
        @(negedge clk);
        set_go(1'b0, 0);
    endtask

    task automatic wait_done(string name);
        int k;
        k = 0;
        while (!(if0.done && if1.done && if2.done) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_done"}, {if0.done, if1.done, if2.done}, 3'b111);
        chk({name, "_idle"}, {if0.busy, if1.busy, if2.busy}, 3'b000);
    endtask

    task automatic readback();
        for (int a = 0; a < 16; a++) begin
            set_raddr(4'(a));
            rd_en = 1'b1;
            @(negedge clk);
        end
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic sweep(string name, longint unsigned s);
        kick(s);
        wait_done(name);
        readback();
    endtask

    initial begin
        reset_n = 1'b0;
        rd_en   = 1'b0;
        bprev   = 1'b0;
        cur_start = 0;
        set_go(1'b0, 0);
        set_raddr(4'd0);

        chk("pin_m1", model(1, 32), 0);
        chk("pin_m2", model(2, 32), 1);
        chk("pin_m3", model(3, 32), 7);
        chk("pin_m6", model(6, 32), 8);
        chk("pin_m7", model(7, 32), 16);
        chk("pin_m9", model(9, 32), 19);
        chk("pin_m27", model(27, 32), 111);
        chk("pin_m27w8", model(27, 8), 17'h1FFFF);
        chk("pin_m0", model(0, 32), 0);

        repeat (3) @(negedge clk);
        chk("rst_busy", {if0.busy, if1.busy, if2.busy}, 0);
        chk("rst_done", {if0.done, if1.done, if2.done}, 0);
        chk("rst_rdata", {if0.rdata, if1.rdata, if2.rdata}, 0);
        chk("rst_rovf", {if0.rovf, if1.rovf, if2.rovf}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        kick(1);
        chk("busy_after_go", {if0.busy, if1.busy, if2.busy}, 3'b111);
        wait_done("s1");
        readback();
`ifdef COLLATZ_SWEEP_MAXTRACK_EN
        chk("max_count", if0.max_count, 19);
        chk("max_start", if0.max_start, 9);
        chk("max_count_l1", if1.max_count, 19);
        chk("max_start_l1", if1.max_start, 9);
`endif

        sweep("s27", 27);
        set_raddr(4'd0);
        @(negedge clk);
        @(negedge clk);
        chk("s27_l4_m0", if0.rdata, 111);
        chk("s27_l1_m0", if1.rdata, 111);
        chk("s27_w8_m0", {if2.rovf, if2.rdata}, 17'h1FFFF);

        sweep("s0", 0);
        sweep("s2", 2);

        kick(5);
        repeat (3) @(negedge clk);
        set_go(1'b1, 100);
        @(negedge clk);
        set_go(1'b0, 0);
        wait_done("s5go");
        readback();

        kick(27);
        repeat (4) @(negedge clk);
        chk("mid_busy", {if0.busy, if1.busy, if2.busy}, 3'b111);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", {if0.busy, if1.busy, if2.busy}, 0);
        chk("abort_done", {if0.done, if1.done, if2.done}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        sweep("s1b", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
